// File: rtl/lsu_mem_pkg.sv
// Shared types for the load/store controller: access size, FSM state and per-size geometry.
// Ports: none (package).
// size_info() maps an access size to its byte count and the SRAM store byte mask.
package lsu_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0] nbytes;
    logic [3:0] wmask;
  } size_info_t;

  // Illegal size reports zero bytes; callers flag it as an error before use.
  function automatic size_info_t size_info(input size_e sz);
    size_info_t info;
    case (sz)
      SZ_B:    begin info.nbytes = 3'd1; info.wmask = 4'b0001; end
      SZ_H:    begin info.nbytes = 3'd2; info.wmask = 4'b0011; end
      SZ_W:    begin info.nbytes = 3'd4; info.wmask = 4'b1111; end
      default: begin info.nbytes = 3'd0; info.wmask = 4'b0000; end
    endcase
    return info;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load extension: little-endian raw bytes -> 32-bit sign/zero-extended result.
// Ports: raw (assembled bytes), size (byte/half/word), is_unsigned (zero-extend), result.
// Bytes above the access size are ignored.
module lsu_load_ext
  import lsu_mem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  always_comb begin
    result = raw;
    case (size_e'(size))
      SZ_B:    result = {{24{~is_unsigned & raw[7]}},  raw[7:0]};
      SZ_H:    result = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller driving a byte-entry SRAM: masked stores, byte-serial loads.
// Ports: req_* (CPU request, valid/ready), rsp_* (response, valid/ready), sram_* (macro pins).
// Out-of-range or illegal-size requests answer with rsp_err and never touch the SRAM pins.
module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [NUM_WMASKS-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);
  import lsu_mem_pkg::*;

  state_e                state, state_nxt;
  logic [1:0]            k;
  logic [ADDR_WIDTH-1:0] addr_q;
  size_e                 size_q;
  logic                  uns_q;
  logic [31:0]           raw_q, raw_nxt, ext_out;
  size_info_t            req_info, cur_info;
  logic [ADDR_WIDTH:0]   req_end;
  logic                  req_err, accept, last_wr, last_rd;

  // Only the low byte of each read is meaningful on a byte-entry macro.
  logic unused_bits;
  assign unused_bits = ^{sram_dout[DATA_WIDTH-1:8], cur_info.wmask};

  always_comb begin
    req_info  = size_info(size_e'(req_size));
    cur_info  = size_info(size_q);
    // One extra bit so an access running past the top is caught instead of wrapping.
    req_end   = {1'b0, req_addr} + (ADDR_WIDTH+1)'(req_info.nbytes) - (ADDR_WIDTH+1)'(1);
    req_err   = (req_size == 2'd3) || (req_end > (ADDR_WIDTH+1)'(RAM_DEPTH - 1));
    req_ready = (state == IDLE) && !rst;
    accept    = req_valid && req_ready;
    rsp_valid = (state == RESP);
    // The store pins are held for two cycles to cover the macro's input register.
    last_wr   = (k == 2'd1);
    last_rd   = ({1'b0, k} == cur_info.nbytes - 3'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = req_err ? RESP : (req_we ? WR : RD);
      WR:      if (last_wr)   state_nxt = RESP;
      RD:      if (last_rd)   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Byte k arriving this cycle merged in, so the final byte feeds the extender directly.
  always_comb begin
    raw_nxt = raw_q;
    raw_nxt[{k, 3'b000} +: 8] = sram_dout[7:0];
  end

  lsu_load_ext u_ext (
    .raw         (raw_nxt),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (ext_out)
  );

  // SRAM pins are registered: they are set up on the edge that enters WR/RD.
  always_ff @(posedge clk) begin
    if (rst) begin
      k          <= 2'd0;
      addr_q     <= '0;
      size_q     <= SZ_B;
      uns_q      <= 1'b0;
      raw_q      <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      sram_csb   <= 1'b1;
      sram_web   <= 1'b0;
      sram_wmask <= '0;
      sram_addr  <= '0;
      sram_din   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          addr_q    <= req_addr;
          size_q    <= size_e'(req_size);
          uns_q     <= req_unsigned;
          k         <= 2'd0;
          raw_q     <= '0;
          rsp_rdata <= '0;
          rsp_err   <= req_err;
          if (!req_err) begin
            sram_csb   <= 1'b0;
            sram_web   <= req_we;
            sram_wmask <= req_we ? NUM_WMASKS'(req_info.wmask) : '0;
            sram_addr  <= req_addr;
            if (req_we) sram_din <= req_wdata;
          end
        end
        WR: begin
          if (last_wr) begin
            k          <= 2'd0;
            sram_csb   <= 1'b1;
            sram_web   <= 1'b0;
            sram_wmask <= '0;
          end else begin
            k <= k + 2'd1;
          end
        end
        RD: begin
          raw_q <= raw_nxt;
          if (last_rd) begin
            k         <= 2'd0;
            rsp_rdata <= DATA_WIDTH'(ext_out);
            sram_csb  <= 1'b1;
          end else begin
            k         <= k + 2'd1;
            sram_addr <= addr_q + ADDR_WIDTH'(k) + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: byte-entry SRAM model plus a byte-array reference memory.
// Ports: none (top-level bench).
// Directed, backpressure, reset and randomized scenarios, each checking inline.
module tb_lsu_mem_ctrl;

  localparam int AW    = 13;
  localparam int DW    = 32;
  localparam int NW    = 4;
  localparam int DEPTH = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          sram_csb, sram_web;
  logic [NW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;

  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // SRAM model: byte per entry, combinational read, masked write at the clock edge.
  logic [7:0] sram_mem [DEPTH];
  logic       mem_clear;
  assign sram_dout = {24'h0, sram_mem[sram_addr]};
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < DEPTH; i++) sram_mem[i] <= 8'h00;
    end else if (!sram_csb && sram_web) begin
      for (int i = 0; i < NW; i++)
        if (sram_wmask[i] && (int'(sram_addr) + i < DEPTH))
          sram_mem[sram_addr + AW'(i)] <= sram_din[8*i +: 8];
    end
  end

  // Reference model
  logic [7:0] ref_mem [DEPTH];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic int nbytes_of(input int sz);
    return (sz == 0) ? 1 : (sz == 1) ? 2 : (sz == 2) ? 4 : 0;
  endfunction

  function automatic bit ref_err(input int addr, input int sz);
    return (sz == 3) || (addr + nbytes_of(sz) - 1 > DEPTH - 1);
  endfunction

  function automatic logic [31:0] ref_load(input int addr, input int sz, input bit uns);
    int     n;
    longint v;
    n = nbytes_of(sz);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[addr + i]) << (8 * i));
    if (!uns && n < 4 && ((v >> (8 * n - 1)) & 1) != 0) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input int addr, input int sz, input logic [31:0] wd);
    if (!ref_err(addr, sz))
      for (int i = 0; i < nbytes_of(sz); i++) ref_mem[addr + i] = wd[8*i +: 8];
  endtask

  // Observations from the last issued request
  int         ob_lat, ob_wr, ob_rd, ob_pin_bad;
  logic [3:0] ob_wm [2];
  logic       ob_rdy;

  // Called at #1 after an edge; that cycle is cycle 0 (acceptance).
  task automatic issue(input bit we, input int sz, input bit uns, input int addr,
                       input logic [31:0] wd);
    ob_rdy       = req_ready;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz[1:0];
    req_unsigned = uns;
    req_addr     = addr[AW-1:0];
    req_wdata    = wd;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    ob_lat     = 1;
    ob_wr      = 0;
    ob_rd      = 0;
    ob_pin_bad = 0;
    ob_wm[0]   = 4'h0;
    ob_wm[1]   = 4'h0;
    while (!rsp_valid && ob_lat < 20) begin
      if (!sram_csb && sram_web) begin
        if (ob_wr < 2) ob_wm[ob_wr] = sram_wmask;
        if (sram_addr !== addr[AW-1:0] || sram_din !== wd) ob_pin_bad++;
        ob_wr++;
      end
      if (!sram_csb && !sram_web) begin
        if (sram_addr !== AW'(addr + ob_rd) || sram_wmask !== 4'h0) ob_pin_bad++;
        ob_rd++;
      end
      @(posedge clk); #1;
      ob_lat++;
    end
    n_checks++;
    if (!rsp_valid) $display("FAIL rsp_timeout addr=%0h got rsp_valid=%b want 1", addr, rsp_valid);
    else n_pass++;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_clear = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    mem_clear = 1'b0;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready got %b want 0", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rsp_rdata got %h want 0", rsp_rdata); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL rst_rsp_err got %b want 0", rsp_err); else n_pass++;
    n_checks++;
    if ({sram_csb, sram_web, sram_wmask} !== 6'b100000)
      $display("FAIL rst_sram_ctl got csb=%b web=%b wmask=%b want 1 0 0000", sram_csb, sram_web, sram_wmask);
    else n_pass++;
    n_checks++;
    if (sram_addr !== 13'h0 || sram_din !== 32'h0)
      $display("FAIL rst_sram_data got addr=%h din=%h want 0 0", sram_addr, sram_din);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", req_ready); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    issue(1'b1, 2, 1'b0, 'h010, 32'hDEADBEEF);
    n_checks++; if (ob_lat !== 3) $display("FAIL st_word_latency got %0d want 3", ob_lat); else n_pass++;
    n_checks++;
    if (ob_wr !== 2 || ob_wm[0] !== 4'b1111 || ob_wm[1] !== 4'b1111)
      $display("FAIL st_word_wmask got cycles=%0d wm=%b,%b want 2 1111,1111", ob_wr, ob_wm[0], ob_wm[1]);
    else n_pass++;
    finish_rsp();
    ref_store('h010, 2, 32'hDEADBEEF);

    issue(1'b0, 2, 1'b0, 'h010, 32'h0);
    n_checks++; if (rsp_rdata !== 32'hDEADBEEF) $display("FAIL ld_word got %h want deadbeef", rsp_rdata); else n_pass++;
    n_checks++; if (ob_lat !== 5) $display("FAIL ld_word_latency got %0d want 5", ob_lat); else n_pass++;
    finish_rsp();
    n_checks++; if (req_ready !== 1'b1) $display("FAIL back_to_back_ready got %b want 1", req_ready); else n_pass++;

    issue(1'b0, 0, 1'b1, 'h011, 32'h0);
    n_checks++; if (rsp_rdata !== 32'h000000BE) $display("FAIL ld_ubyte got %h want 000000be", rsp_rdata); else n_pass++;
    n_checks++; if (ob_lat !== 2) $display("FAIL ld_byte_latency got %0d want 2", ob_lat); else n_pass++;
    finish_rsp();
    issue(1'b0, 0, 1'b0, 'h011, 32'h0);
    n_checks++; if (rsp_rdata !== 32'hFFFFFFBE) $display("FAIL ld_sbyte got %h want ffffffbe", rsp_rdata); else n_pass++;
    finish_rsp();

    issue(1'b1, 1, 1'b0, 'h021, 32'h1234ABCD);
    n_checks++;
    if (ob_wr !== 2 || ob_wm[0] !== 4'b0011 || ob_wm[1] !== 4'b0011)
      $display("FAIL st_half_wmask got cycles=%0d wm=%b,%b want 2 0011,0011", ob_wr, ob_wm[0], ob_wm[1]);
    else n_pass++;
    n_checks++; if (ob_lat !== 3) $display("FAIL st_half_latency got %0d want 3", ob_lat); else n_pass++;
    finish_rsp();
    ref_store('h021, 1, 32'h1234ABCD);
    issue(1'b0, 2, 1'b0, 'h020, 32'h0);
    n_checks++; if (rsp_rdata !== 32'h00ABCD00) $display("FAIL ld_unaligned got %h want 00abcd00", rsp_rdata); else n_pass++;
    finish_rsp();
    issue(1'b0, 1, 1'b0, 'h021, 32'h0);
    n_checks++; if (rsp_rdata !== 32'hFFFFABCD) $display("FAIL ld_shalf got %h want ffffabcd", rsp_rdata); else n_pass++;
    n_checks++; if (ob_lat !== 3) $display("FAIL ld_half_latency got %0d want 3", ob_lat); else n_pass++;
    finish_rsp();
  endtask

  task automatic test_errors();
    issue(1'b0, 2, 1'b0, 'h1FFE, 32'h0);
    n_checks++; if (rsp_err !== 1'b1) $display("FAIL err_range got %b want 1", rsp_err); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL err_rdata got %h want 0", rsp_rdata); else n_pass++;
    n_checks++; if (ob_lat !== 1) $display("FAIL err_latency got %0d want 1", ob_lat); else n_pass++;
    n_checks++; if (ob_rd + ob_wr !== 0) $display("FAIL err_csb got %0d active cycles want 0", ob_rd + ob_wr); else n_pass++;
    finish_rsp();
    issue(1'b0, 0, 1'b1, 'h1FFF, 32'h0);
    n_checks++;
    if (rsp_err !== 1'b0 || rsp_rdata !== ref_load('h1FFF, 0, 1'b1))
      $display("FAIL top_byte got err=%b data=%h want 0 %h", rsp_err, rsp_rdata, ref_load('h1FFF, 0, 1'b1));
    else n_pass++;
    finish_rsp();
    issue(1'b1, 3, 1'b0, 'h040, 32'h55AA55AA);
    n_checks++;
    if (rsp_err !== 1'b1 || ob_wr !== 0)
      $display("FAIL err_size got err=%b wr_cycles=%0d want 1 0", rsp_err, ob_wr);
    else n_pass++;
    finish_rsp();
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    issue(1'b0, 2, 1'b1, 'h010, 32'h0);
    held = rsp_rdata;
    n_checks++; if (held !== 32'hDEADBEEF) $display("FAIL bp_data got %h want deadbeef", held); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0)
        $display("FAIL bp_hold cyc=%0d got valid=%b data=%h ready=%b want 1 %h 0",
                 c, rsp_valid, rsp_rdata, req_ready, held);
      else n_pass++;
    end
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(1'b1, 2, 1'b0, 'h100, 32'hA5A55A5A);
    finish_rsp();
    ref_store('h100, 2, 32'hA5A55A5A);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 13'h100;
    @(posedge clk); #1;   // cycle 1
    req_valid = 1'b0;
    @(posedge clk); #1;   // cycle 2
    rst = 1'b1;
    @(posedge clk); #1;   // cycle 3
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b0)
      $display("FAIL midrst_rsp got valid=%b data=%h err=%b ready=%b want 0 0 0 0",
               rsp_valid, rsp_rdata, rsp_err, req_ready);
    else n_pass++;
    n_checks++;
    if (sram_csb !== 1'b1 || sram_web !== 1'b0 || sram_wmask !== 4'h0 || sram_addr !== 13'h0 || sram_din !== 32'h0)
      $display("FAIL midrst_sram got csb=%b web=%b wm=%b addr=%h din=%h want 1 0 0 0 0",
               sram_csb, sram_web, sram_wmask, sram_addr, sram_din);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", req_ready); else n_pass++;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL midrst_no_rsp got %0d valid cycles want 0", seen); else n_pass++;
  endtask

  task automatic test_random();
    bit          we, uns, err;
    int          sz, addr, n, exp_lat;
    logic [31:0] wd, exp_data;
    logic [3:0]  exp_wm;
    for (int t = 0; t < 80; t++) begin
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      addr = ($urandom_range(0, 3) == 0) ? DEPTH - int'($urandom_range(1, 5)) : int'($urandom_range(0, 47));
      wd   = $urandom;
      n    = nbytes_of(sz);
      err  = ref_err(addr, sz);
      exp_lat  = err ? 1 : (we ? 3 : n + 1);
      exp_data = (err || we) ? 32'h0 : ref_load(addr, sz, uns);
      exp_wm   = 4'((1 << n) - 1);
      issue(we, sz, uns, addr, wd);
      n_checks++; if (ob_rdy !== 1'b1) $display("FAIL rnd_ready t=%0d got %b want 1", t, ob_rdy); else n_pass++;
      n_checks++; if (rsp_err !== err) $display("FAIL rnd_err t=%0d got %b want %b", t, rsp_err, err); else n_pass++;
      n_checks++;
      if (rsp_rdata !== exp_data) $display("FAIL rnd_data t=%0d a=%0h sz=%0d u=%b got %h want %h", t, addr, sz, uns, rsp_rdata, exp_data);
      else n_pass++;
      n_checks++; if (ob_lat !== exp_lat) $display("FAIL rnd_latency t=%0d got %0d want %0d", t, ob_lat, exp_lat); else n_pass++;
      n_checks++;
      if (ob_wr !== ((we && !err) ? 2 : 0) || ob_rd !== ((!we && !err) ? n : 0))
        $display("FAIL rnd_cycles t=%0d got wr=%0d rd=%0d want %0d %0d", t, ob_wr, ob_rd,
                 (we && !err) ? 2 : 0, (!we && !err) ? n : 0);
      else n_pass++;
      n_checks++; if (ob_pin_bad !== 0) $display("FAIL rnd_pins t=%0d got %0d bad cycles want 0", t, ob_pin_bad); else n_pass++;
      if (we && !err) begin
        n_checks++;
        if (ob_wm[0] !== exp_wm || ob_wm[1] !== exp_wm)
          $display("FAIL rnd_wmask t=%0d got %b,%b want %b", t, ob_wm[0], ob_wm[1], exp_wm);
        else n_pass++;
        ref_store(addr, sz, wd);
      end
      finish_rsp();
    end
  endtask

  initial begin
    rst = 1'b1; mem_clear = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want summary before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller that sits directly upstream of the byte-entry `sram` macro. It accepts one CPU load or store per handshake (byte/half/word, signed or unsigned) and sequences the SRAM pins. Stores go out as one masked write. Loads go out as one single-byte read per byte, assembled little-endian and sign- or zero-extended. Out-of-range accesses are rejected with an error response instead of touching memory.

## Interface
Parameters:
- `ADDR_WIDTH`, 13: SRAM byte-address width.
- `DATA_WIDTH`, 32: request/SRAM data width.
- `NUM_WMASKS`, 4: SRAM byte-mask width.
- `RAM_DEPTH`, `1 << ADDR_WIDTH`: number of SRAM entries (one byte each).

Ports:
- `clk`  in  1: the single clock; all state on rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: controller can accept.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned`  in  1: load zero-extends when 1, sign-extends when 0.
- `req_addr`  in  `ADDR_WIDTH`: byte address; any alignment is legal.
- `req_wdata`  in  `DATA_WIDTH`: store data, byte i in bits [8i+7:8i].
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: response consumed.
- `rsp_rdata`  out  `DATA_WIDTH`: load result; 0 for stores and errors.
- `rsp_err`  out  1: range or size error.
- `sram_csb`  out  1: chip select, active-low.
- `sram_web`  out  1: 1 = write (SRAM polarity).
- `sram_wmask`  out  `NUM_WMASKS`: byte mask.
- `sram_addr`  out  `ADDR_WIDTH`: SRAM address.
- `sram_din`  out  `DATA_WIDTH`: SRAM write data.
- `sram_dout`  in  `DATA_WIDTH`: combinational read of `mem[sram_addr]`; only bits [7:0] are used.

## Operation
**States**
- IDLE, WR, RD, RESP.

**Request acceptance**
- `req_ready` = 1 only in IDLE and not in reset.
- A request is accepted on `req_valid && req_ready`. Address, size, unsigned flag and data are latched on acceptance.
- Byte count n = 1/2/4 by size.
- Error when size = 3, or when `addr + n - 1` exceeds `RAM_DEPTH-1`. Compute this in `ADDR_WIDTH+1` bits; no wrap-around.
- An erroring request goes IDLE → RESP with `rsp_err` = 1 and `rsp_rdata` = 0. No SRAM pin changes.

**Store (WR)**
- `sram_csb` = 0, `sram_web` = 1, `sram_addr` = addr.
- `sram_wmask` = 0001 / 0011 / 1111 for byte / half / word.
- `sram_din` = `req_wdata`, unshifted.
- Hold these for exactly 2 cycles, to cover the SRAM's registered-input commit; the repeated write is idempotent. Then go to RESP.

**Load (RD)**
- Byte counter k runs 0..n-1.
- Each cycle: `sram_csb` = 0, `sram_web` = 0, `sram_wmask` = 0, `sram_addr` = addr+k.
- Capture `sram_dout[7:0]` into result byte k at the clock edge.
- After byte n-1, extend (bit 7 or bit 15 for signed byte/half loads), register into `rsp_rdata`, go to RESP.

**Response (RESP)**
- `rsp_valid` = 1. `rsp_rdata` and `rsp_err` are stable until `rsp_ready`; then go to IDLE.
- SRAM pins are idle outside WR and RD: csb=1, web=0, wmask=0; addr and din hold their last value.

## Timing
- Cycle 0 is the acceptance cycle. `rsp_valid` first rises in:
  - error: cycle 1
  - byte load: cycle 2
  - half load: cycle 3
  - word load: cycle 5
  - store: cycle 3
- Back-to-back throughput: the next request can be accepted in the cycle after the `rsp_valid && rsp_ready` handshake.
- Read-after-write ordering: a load accepted after a store's response returns the new data.
- Reset values, taking effect the edge after `rst` is seen high:
  - `req_ready` 0 while `rst` is high, 1 the cycle after deassert.
  - `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0.
  - `sram_csb` 1, `sram_web` 0, `sram_wmask` 0, `sram_addr` 0, `sram_din` 0.
  - State IDLE, k = 0.
- Reset mid-operation aborts with no response. A store interrupted in WR may or may not have committed.

## Structure
- Package `lsu_mem_pkg`: size enum (`SZ_B`=0, `SZ_H`=1, `SZ_W`=2), state enum (IDLE/WR/RD/RESP), and a function giving byte count and wmask from size.
- Sub-module `lsu_load_ext`: combinational load extension (raw bytes, size, unsigned → 32-bit result). Instantiated once.

## Test plan
- Word store of 0xDEADBEEF at 0x010, then word load at 0x010 → 0xDEADBEEF. Unsigned byte load at 0x011 → 0x000000BE; signed → 0xFFFFFFBE.
- On a zeroed SRAM, half store of 0x1234ABCD at 0x021 (unaligned) → wmask 0011 during both WR cycles. Word load at 0x020 → 0x00ABCD00.
- Word load at 0x1FFE → `rsp_err`=1, `rsp_rdata`=0, response in cycle 1, `sram_csb` never 0. Byte load at 0x1FFF → succeeds. size=3 → `rsp_err`=1.
- Latency check: byte/half/word loads and store give `rsp_valid` in cycles 2/3/5/3. With `rsp_ready` held low 5 cycles, `rsp_rdata` stays stable and `req_ready` stays 0.
- `rst` asserted in cycle 2 of a word load → all outputs at reset values the next cycle; no response ever issued; `req_ready`=1 one cycle after `rst` falls.
